nes_pad_poller: RTL and testbench

Sequencer for the NES/SNES-style controller port on the `uio` pins. On each frame-tick request it drives the latch and clock pulses, shifts in the 8 serial button bits, and presents a registered, active-high button word. It replaces direct `ui_in` button wiring ahead of `InputController` and runs off the system pixel clock. The sync generator's `frame_end` drives its `start` input.

---
 rtl/nes_pad_poller_if.sv | 35 +++
 rtl/nes_pad_poller.sv | 142 ++++++++++++++
 tb/tb_nes_pad_poller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_poller_if.sv
// Signal bundle between the controller-port sequencer and whoever consumes it.
// The master side is the poller itself; the slave side feeds start/nes_data
// and observes the pad pins and the decoded button word.
interface nes_pad_poller_if;
  logic       start;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;
  logic       pad_present;

  modport master (
    input  start,
    input  nes_data,
    output nes_latch,
    output nes_clk,
    output buttons,
    output valid,
    output busy,
    output pad_present
  );

  modport slave (
    output start,
    output nes_data,
    input  nes_latch,
    input  nes_clk,
    input  buttons,
    input  valid,
    input  busy,
    input  pad_present
  );
endinterface

// File: rtl/nes_pad_poller.sv
// NES/SNES controller-port sequencer. On a start pulse it raises the latch,
// then clocks the 8 serial button bits in (7 shift pulses, since bit 0 is
// already on the line after the latch) and publishes an active-high button
// word together with a pad-present flag and a one-cycle valid strobe.
module nes_pad_poller #(
  parameter int HALF_PERIOD = 75
) (
  input  logic              clk,
  input  logic              rst_n,
  nes_pad_poller_if.master  bus
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_WAIT0  = 3'd2;
  localparam logic [2:0] S_CLK_HI = 3'd3;
  localparam logic [2:0] S_CLK_LO = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    raw_q, raw_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          pad_present_q, pad_present_d;
  logic          valid_q, valid_d;

  // Two-flop synchronizer for the asynchronous serial line from the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.nes_data;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: phase timing, bit capture and result publication.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    raw_d         = raw_q;
    buttons_d     = buttons_q;
    pad_present_d = pad_present_q;
    valid_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LATCH;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_WAIT0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT0: begin
        if (cnt_q == HALF_LAST) begin
          raw_d[0]  = sync2_q;
          bit_idx_d = 3'd1;
          state_d   = S_CLK_HI;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLK_HI: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          raw_d[bit_idx_q] = sync2_q;
          cnt_d            = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            state_d   = S_CLK_HI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        valid_d       = 1'b1;
        pad_present_d = (raw_q != 8'h00);
        buttons_d     = (raw_q == 8'h00) ? 8'h00 : ~raw_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      raw_q         <= 8'h00;
      buttons_q     <= 8'h00;
      pad_present_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      raw_q         <= raw_d;
      buttons_q     <= buttons_d;
      pad_present_q <= pad_present_d;
      valid_q       <= valid_d;
    end
  end

  assign bus.nes_latch   = (state_q == S_LATCH);
  assign bus.nes_clk     = (state_q == S_CLK_HI);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.buttons     = buttons_q;
  assign bus.valid       = valid_q;
  assign bus.pad_present = pad_present_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: a pad modelled as a latch-loaded shift register
// drives the serial line, and every poll is checked cycle by cycle against
// timing and button values derived directly from the protocol rules.
module tb_nes_pad_poller;

  localparam int H4 = 4;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] heldButtons = 8'h00;
  logic       heldPresent = 1'b0;

  nes_pad_poller_if bus4();
  nes_pad_poller_if bus75();

  nes_pad_poller #(.HALF_PERIOD(H4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  nes_pad_poller #(.HALF_PERIOD(75)) dut75 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus75)
  );

  // Free-running clock once enabled, so reset can first be checked clockless.
  always #5 if (clk_en) clk = ~clk;

  // Pad model for the H=4 instance: load on latch, shift on clock rise.
  logic [7:0] pad4_raw = 8'hFF;
  logic [7:0] pad4_sr  = 8'hFF;
  logic       no_pad4  = 1'b0;
  always @(posedge bus4.nes_clk or posedge bus4.nes_latch) begin
    if (bus4.nes_latch) pad4_sr <= pad4_raw;
    else                pad4_sr <= {1'b1, pad4_sr[7:1]};
  end
  assign bus4.nes_data = no_pad4 ? 1'b0 : pad4_sr[0];

  // Pad model for the H=75 instance.
  logic [7:0] pad75_raw = 8'hFF;
  logic [7:0] pad75_sr  = 8'hFF;
  always @(posedge bus75.nes_clk or posedge bus75.nes_latch) begin
    if (bus75.nes_latch) pad75_sr <= pad75_raw;
    else                 pad75_sr <= {1'b1, pad75_sr[7:1]};
  end
  assign bus75.nes_data = pad75_sr[0];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expClk(input int k, input int h);
    for (int j = 1; j <= 7; j++)
      if (k >= 3*h + (2*j-2)*h + 1 && k <= 3*h + (2*j-1)*h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] expButtons(input logic [7:0] line);
    if (line == 8'h00) return 8'h00;
    return ~line;
  endfunction

  // One full poll on the H=4 instance, checked every cycle.
  task automatic applyStimulus(input logic [7:0] raw, input bit noPad,
                               input bit busyStarts, input bit chainNext,
                               input bit preStarted);
    int         lastCycle;
    int         rises;
    logic       prevClk;
    logic [7:0] line;
    lastCycle = 17*H4 + 2;
    pad4_raw  = raw;
    no_pad4   = noPad;
    line      = noPad ? 8'h00 : raw;
    if (!preStarted) begin
      @(negedge clk);
      bus4.start = 1'b1;
    end
    rises   = 0;
    prevClk = 1'b0;
    for (int k = 1; k <= lastCycle; k++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (bus4.nes_clk && !prevClk) rises++;
      prevClk = bus4.nes_clk;
      checkOutput($sformatf("latch@%0d", k), 32'(bus4.nes_latch), 32'(k >= 1 && k <= 2*H4));
      checkOutput($sformatf("nes_clk@%0d", k), 32'(bus4.nes_clk), 32'(expClk(k, H4)));
      checkOutput($sformatf("busy@%0d", k), 32'(bus4.busy), 32'(k <= 17*H4 + 1));
      checkOutput($sformatf("valid@%0d", k), 32'(bus4.valid), 32'(k == lastCycle));
      if (k == lastCycle) begin
        heldButtons = expButtons(line);
        heldPresent = (line != 8'h00);
      end
      checkOutput($sformatf("buttons@%0d", k), 32'(bus4.buttons), 32'(heldButtons));
      checkOutput($sformatf("present@%0d", k), 32'(bus4.pad_present), 32'(heldPresent));
      if (busyStarts && (k == 5 || k == 40 || k == 69)) bus4.start = 1'b1;
      if (chainNext && k == lastCycle) bus4.start = 1'b1;
    end
    checkOutput("clk_pulses", 32'(rises), 32'd7);
  endtask

  // Idle cycles on the H=4 instance: nothing may move, results are held.
  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput("idle_latch", 32'(bus4.nes_latch), 32'd0);
      checkOutput("idle_clk", 32'(bus4.nes_clk), 32'd0);
      checkOutput("idle_busy", 32'(bus4.busy), 32'd0);
      checkOutput("idle_valid", 32'(bus4.valid), 32'd0);
      checkOutput("idle_buttons", 32'(bus4.buttons), 32'(heldButtons));
    end
  endtask

  initial begin
    logic [7:0] r;
    int         latchCount, latchFirst, validCycle, rises;
    logic       prev;
    logic [7:0] capButtons;
    logic       capPresent;

    bus4.start  = 1'b0;
    bus75.start = 1'b0;

    // Reset without any clock edge.
    #1 rst_n = 1'b0;
    #4;
    checkOutput("rst_latch", 32'(bus4.nes_latch), 32'd0);
    checkOutput("rst_clk", 32'(bus4.nes_clk), 32'd0);
    checkOutput("rst_buttons", 32'(bus4.buttons), 32'd0);
    checkOutput("rst_valid", 32'(bus4.valid), 32'd0);
    checkOutput("rst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("rst_present", 32'(bus4.pad_present), 32'd0);
    checkOutput("rst75_busy", 32'(bus75.busy), 32'd0);
    #10 rst_n = 1'b1;
    #3 clk_en = 1'b1;
    idleCycles(200);

    // A+Up with stray starts while busy, then a start exactly at completion.
    applyStimulus(8'b1110_1110, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("a_up_buttons", 32'(heldButtons), 32'h11);
    applyStimulus(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(10);

    // Result hold between polls.
    applyStimulus(8'b1110_1110, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(50);
    checkOutput("hold_buttons", 32'(bus4.buttons), 32'h11);

    // No pad on the line.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nopad_present", 32'(bus4.pad_present), 32'd0);
    idleCycles(5);

    // Randomized pad states, including the all-released pattern.
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 8'hFF : 8'($urandom);
      applyStimulus(r, 1'b0, 1'b0, 1'b0, 1'b0);
      idleCycles($urandom_range(0, 5));
    end

    // Mid-poll reset: outputs must drop before the next clock edge.
    applyStimulus(8'b1110_1110, 1'b0, 1'b0, 1'b0, 1'b0);
    pad4_raw = 8'($urandom);
    @(negedge clk);
    bus4.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus4.start = 1'b0;
    end
    checkOutput("pre_rst_clk", 32'(bus4.nes_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_clk", 32'(bus4.nes_clk), 32'd0);
    checkOutput("midrst_latch", 32'(bus4.nes_latch), 32'd0);
    checkOutput("midrst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("midrst_buttons", 32'(bus4.buttons), 32'd0);
    checkOutput("midrst_present", 32'(bus4.pad_present), 32'd0);
    heldButtons = 8'h00;
    heldPresent = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);
    applyStimulus(8'b0111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("right_buttons", 32'(bus4.buttons), 32'h80);

    // Default half period: timing scales with H=75.
    pad75_raw = 8'($urandom);
    @(negedge clk);
    bus75.start = 1'b1;
    latchCount = 0;
    latchFirst = -1;
    validCycle = -1;
    rises      = 0;
    prev       = 1'b0;
    capButtons = 8'h00;
    capPresent = 1'b0;
    for (int k = 1; k <= 1400; k++) begin
      @(negedge clk);
      bus75.start = 1'b0;
      if (bus75.nes_latch) begin
        latchCount++;
        if (latchFirst < 0) latchFirst = k;
      end
      if (bus75.nes_clk && !prev) rises++;
      prev = bus75.nes_clk;
      if (bus75.valid && validCycle < 0) begin
        validCycle = k;
        capButtons = bus75.buttons;
        capPresent = bus75.pad_present;
      end
      if (validCycle >= 0 && k >= validCycle + 2) break;
    end
    checkOutput("h75_latch_len", 32'(latchCount), 32'd150);
    checkOutput("h75_latch_first", 32'(latchFirst), 32'd1);
    checkOutput("h75_valid_cycle", 32'(validCycle), 32'd1277);
    checkOutput("h75_clk_pulses", 32'(rises), 32'd7);
    checkOutput("h75_buttons", 32'(capButtons), 32'(expButtons(pad75_raw)));
    checkOutput("h75_present", 32'(capPresent), 32'(pad75_raw != 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
